// File: rtl/pulse_receiver_symbol_capture.sv
// Pulse-width receiver: measures each pulse on a synchronized line, classifies it
// into a {level, long} symbol, packs 16 symbols per word and hands words out via valid/ready.
module pulse_receiver_symbol_capture #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sig_in,
  input  logic               cfg_invert,
  input  logic [3:0]         cfg_prescaler,
  input  logic [TIMER_W-1:0] cfg_threshold,
  input  logic [TIMER_W-1:0] cfg_timeout,
  input  logic               word_ready,
  input  logic               clr_overflow,
  output logic [31:0]        word_data,
  output logic               word_valid,
  output logic [4:0]         word_count,
  output logic               frame_done,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e             state_q, state_d;
  logic               prev_q;
  logic [14:0]        presc_q, presc_d;
  logic [TIMER_W-1:0] dur_q, dur_d;
  logic [3:0]         idx_q, idx_d;
  logic [31:0]        shift_q, shift_d;
  logic [31:0]        data_q, data_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               fd_q, fd_d;
  logic               ovf_q, ovf_d;

  logic               level, edge_s, tick, timeout;
  logic [15:0]        presc_pow;
  logic [14:0]        presc_top;
  logic [TIMER_W:0]   dur_plus1;
  logic [1:0]         sym;
  logic [31:0]        slot_word;
  logic               push;
  logic [31:0]        push_data;
  logic [4:0]         push_cnt;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (&v) ? v : v + {{(TIMER_W-1){1'b0}}, 1'b1};
  endfunction

  assign level     = sig_in ^ cfg_invert;
  assign edge_s    = level != prev_q;
  assign presc_pow = 16'd1 << cfg_prescaler;
  assign presc_top = presc_pow[14:0] - 15'd1;
  assign tick      = presc_q == presc_top;
  assign dur_plus1 = {1'b0, dur_q} + {{TIMER_W{1'b0}}, 1'b1};
  // An edge in the same cycle always wins over the idle timeout.
  assign timeout   = (state_q == MEASURE) && (cfg_timeout != '0) && tick && !edge_s &&
                     (dur_plus1 == {1'b0, cfg_timeout});
  assign sym       = {prev_q, dur_q >= cfg_threshold};
  assign slot_word = shift_q | (32'(sym) << {idx_q, 1'b0});

  always_comb begin
    state_d   = state_q;
    presc_d   = (edge_s || tick) ? 15'd0 : presc_q + 15'd1;
    dur_d     = edge_s ? '0 : (tick ? sat_inc(dur_q) : dur_q);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    push_data = shift_q;
    push_cnt  = {1'b0, idx_q};
    fd_d      = 1'b0;
    case (state_q)
      IDLE: if (edge_s) state_d = MEASURE;
      MEASURE: begin
        if (edge_s) begin
          if (idx_q == 4'd15) begin
            push      = 1'b1;
            push_data = slot_word;
            push_cnt  = 5'd16;
            idx_d     = 4'd0;
            shift_d   = '0;
          end else begin
            shift_d = slot_word;
            idx_d   = idx_q + 4'd1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          push    = idx_q != 4'd0;
          idx_d   = 4'd0;
          shift_d = '0;
          fd_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling abandons the frame silently; the output side keeps running.
    if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      dur_d   = '0;
      idx_d   = '0;
      shift_d = '0;
      push    = 1'b0;
      fd_d    = 1'b0;
    end
  end

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = clr_overflow ? 1'b0 : ovf_q;
    if (push) begin
      if (!valid_q || word_ready) begin
        data_d  = push_data;
        cnt_d   = push_cnt;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      presc_q <= '0;
      dur_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= level;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_data  = data_q;
  assign word_count = cnt_q;
  assign word_valid = valid_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;
  assign busy       = state_q == MEASURE;

endmodule
